// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-4 Booth sequential multiplier.
package booth_pkg;

  localparam int A_W_DEFAULT    = 12;
  localparam int B_W_DEFAULT    = 12;
  localparam int SIGNED_DEFAULT = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Unsigned operands need one extra window so the top recoded digit sees a 0 sign bit.
  function automatic int booth_steps(input int a_w, input int signed_ops);
    return (signed_ops != 0) ? (a_w + 1) / 2 : a_w / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_r4_sel.sv
// Radix-4 Booth digit selector: maps one 3-bit multiplier window to 0, +/-B or +/-2B.
module booth_r4_sel
  import booth_pkg::*;
#(
  parameter int B_W = B_W_DEFAULT
) (
  input  logic [2:0]     win_i,
  input  logic [B_W+1:0] b_ext_i,
  output logic [B_W+1:0] pp_o
);

  logic [B_W+1:0] b2;

  // Two guard bits in b_ext_i keep 2B and -2B representable, even for the most-negative B.
  assign b2 = {b_ext_i[B_W:0], 1'b0};

  always_comb begin
    pp_o = '0;
    case (win_i)
      3'b001, 3'b010: pp_o = b_ext_i;
      3'b011:         pp_o = b2;
      3'b100:         pp_o = -b2;
      3'b101, 3'b110: pp_o = -b_ext_i;
      default:        pp_o = '0;
    endcase
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-4 Booth multiplier: one recoded digit per clock, valid/ready on both sides.
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int A_W    = A_W_DEFAULT,
  parameter int B_W    = B_W_DEFAULT,
  parameter int SIGNED = SIGNED_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_W-1:0]     mult_a,
  input  logic [B_W-1:0]     mult_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [A_W+B_W-1:0] product
);

  localparam int P_W   = A_W + B_W;
  localparam int STEPS = booth_steps(A_W, SIGNED);
  localparam int MA_W  = 2 * STEPS;
  localparam int ACC_W = P_W + 2;
  localparam int CNT_W = $clog2(STEPS + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  state_e           state_q, state_d;
  logic [MA_W:0]    a_q, a_d;
  logic [B_W+1:0]   b_q, b_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [P_W-1:0]   prod_q, prod_d;

  logic             a_fill;
  logic             b_fill;
  logic [MA_W-1:0]  a_ext;
  logic [B_W+1:0]   b_ext;
  logic [B_W+1:0]   pp;
  logic [ACC_W-1:0] pp_ext;
  logic [ACC_W-1:0] pp_aligned;
  logic [ACC_W-1:0] acc_sum;

  assign a_fill = (SIGNED != 0) && mult_a[A_W-1];
  assign b_fill = (SIGNED != 0) && mult_b[B_W-1];

  generate
    if (MA_W > A_W) begin : g_a_ext
      assign a_ext = {{(MA_W - A_W){a_fill}}, mult_a};
    end else begin : g_a_same
      assign a_ext = mult_a;
    end
  endgenerate

  assign b_ext = {{2{b_fill}}, mult_b};

  // a_q carries the implicit 0 below its LSB; it shifts right two bits per step,
  // so the current window always sits in a_q[2:0].
  booth_r4_sel #(
    .B_W(B_W)
  ) u_sel (
    .win_i  (a_q[2:0]),
    .b_ext_i(b_q),
    .pp_o   (pp)
  );

  assign pp_ext     = {{(ACC_W - B_W - 2){pp[B_W+1]}}, pp};
  assign pp_aligned = pp_ext << {cnt_q, 1'b0};
  assign acc_sum    = acc_q + pp_aligned;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = {a_ext, 1'b0};
          b_d     = b_ext;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_sum;
        a_d   = a_q >> 2;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          prod_d  = acc_sum[P_W-1:0];
          state_d = DONE;
        end
      end
      DONE: begin
        // Product is cleared on the way out so IDLE never shows a stale result.
        if (out_ready) begin
          prod_d  = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign product   = prod_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed tables, handshake/reset corner cases and randomised multi-config runs for booth_mult_seq.
module tb_booth_mult_seq;

  localparam int RND_OPS = 1700;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Default-parameter DUT (12x12 signed)
  logic        d_rst, d_in_valid, d_in_ready, d_out_valid, d_out_ready;
  logic [11:0] d_a, d_b;
  logic [23:0] d_prod;

  booth_mult_seq u_dflt (
    .clk      (clk),
    .rst      (d_rst),
    .in_valid (d_in_valid),
    .in_ready (d_in_ready),
    .mult_a   (d_a),
    .mult_b   (d_b),
    .out_valid(d_out_valid),
    .out_ready(d_out_ready),
    .product  (d_prod)
  );

  // Unsigned 8x8 DUT
  logic        u_rst, u_in_valid, u_in_ready, u_out_valid, u_out_ready;
  logic [7:0]  u_a, u_b;
  logic [15:0] u_prod;

  booth_mult_seq #(
    .A_W(8), .B_W(8), .SIGNED(0)
  ) u_uns (
    .clk      (clk),
    .rst      (u_rst),
    .in_valid (u_in_valid),
    .in_ready (u_in_ready),
    .mult_a   (u_a),
    .mult_b   (u_b),
    .out_valid(u_out_valid),
    .out_ready(u_out_ready),
    .product  (u_prod)
  );

  logic g_rst = 1'b1;
  logic rnd_go = 1'b0;
  bit   rnd_done [6];

  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_rnd
      localparam int AW = (gi / 2 == 0) ? 12 : ((gi / 2 == 1) ? 7 : 16);
      localparam int BW = (gi / 2 == 0) ? 12 : ((gi / 2 == 1) ? 9 : 4);
      localparam int SG = gi % 2;
      localparam int PW = AW + BW;

      logic          r_in_valid, r_in_ready, r_out_valid, r_out_ready;
      logic [AW-1:0] r_a;
      logic [BW-1:0] r_b;
      logic [PW-1:0] r_prod;

      booth_mult_seq #(
        .A_W(AW), .B_W(BW), .SIGNED(SG)
      ) u_dut (
        .clk      (clk),
        .rst      (g_rst),
        .in_valid (r_in_valid),
        .in_ready (r_in_ready),
        .mult_a   (r_a),
        .mult_b   (r_b),
        .out_valid(r_out_valid),
        .out_ready(r_out_ready),
        .product  (r_prod)
      );

      initial begin : p_rnd
        logic [AW-1:0] a;
        logic [BW-1:0] b;
        longint        la, lb;
        logic [63:0]   pe;
        int            t;
        r_in_valid  = 1'b0;
        r_out_ready = 1'b0;
        r_a         = '0;
        r_b         = '0;
        wait (rnd_go);
        @(posedge clk); #1;
        for (int k = 0; k < RND_OPS; k++) begin
          a = AW'($urandom);
          b = BW'($urandom);
          if (SG != 0) begin
            la = longint'($signed(a));
            lb = longint'($signed(b));
          end else begin
            la = longint'(a);
            lb = longint'(b);
          end
          pe = 64'(la * lb);
          r_a = a; r_b = b; r_in_valid = 1'b1; r_out_ready = 1'b1;
          t = 0;
          while (!r_in_ready && t < 20) begin @(posedge clk); #1; t++; end
          @(posedge clk); #1;
          r_in_valid = 1'b0;
          r_a = AW'($urandom);
          r_b = BW'($urandom);
          t = 0;
          while (!r_out_valid && t < 40) begin @(posedge clk); #1; t++; end
          r_out_ready = 1'b0;
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          check($sformatf("rnd%0d_prod", gi), 64'(r_prod), 64'(pe[PW-1:0]));
          r_out_ready = 1'b1;
          @(posedge clk); #1;
          r_out_ready = 1'b0;
        end
        rnd_done[gi] = 1'b1;
      end
    end
  endgenerate

  typedef struct {
    logic [11:0] a;
    logic [11:0] b;
    logic [23:0] p;
  } dvec_t;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } uvec_t;

  task automatic d_op(input logic [11:0] a, input logic [11:0] b,
                      output logic [23:0] p, output int lat, output bit busy_ok);
    int t;
    d_a = a; d_b = b; d_in_valid = 1'b1; d_out_ready = 1'b1;
    t = 0;
    while (!d_in_ready && t < 20) begin @(posedge clk); #1; t++; end
    @(posedge clk); #1;
    d_in_valid = 1'b0;
    d_a = ~a; d_b = ~b;
    lat = 0; busy_ok = 1'b1;
    while (!d_out_valid && lat < 50) begin
      if (d_in_ready || d_prod != 24'd0) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    p = d_prod;
    @(posedge clk); #1;
    d_out_ready = 1'b0;
  endtask

  task automatic u_op(input logic [7:0] a, input logic [7:0] b,
                      output logic [15:0] p, output int lat);
    int t;
    u_a = a; u_b = b; u_in_valid = 1'b1; u_out_ready = 1'b1;
    t = 0;
    while (!u_in_ready && t < 20) begin @(posedge clk); #1; t++; end
    @(posedge clk); #1;
    u_in_valid = 1'b0;
    u_a = ~a; u_b = ~b;
    lat = 0;
    while (!u_out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    p = u_prod;
    @(posedge clk); #1;
    u_out_ready = 1'b0;
  endtask

  initial begin : p_main
    dvec_t       dv [10];
    uvec_t       uv [4];
    logic [23:0] p;
    logic [15:0] up;
    int          lat;
    int          t;
    bit          busy_ok;
    bit          hold_ok;
    bit          seen;
    bit          all_done;

    dv[0] = '{12'd3,    12'd5,    24'h00000F};
    dv[1] = '{12'h800,  12'h800,  24'h400000};
    dv[2] = '{12'h800,  12'h7FF,  24'hC00800};
    dv[3] = '{12'h007,  12'hFFD,  24'hFFFFEB};
    dv[4] = '{12'h7FF,  12'h7FF,  24'h3FF001};
    dv[5] = '{12'h000,  12'h4D2,  24'h000000};
    dv[6] = '{12'hFFF,  12'hFFF,  24'h000001};
    dv[7] = '{12'hFFF,  12'h7FF,  24'hFFF801};
    dv[8] = '{12'h100,  12'h010,  24'h001000};
    dv[9] = '{12'h800,  12'h001,  24'hFFF800};

    uv[0] = '{8'hFF, 8'hFF, 16'hFE01};
    uv[1] = '{8'h80, 8'h02, 16'h0100};
    uv[2] = '{8'hFF, 8'h01, 16'h00FF};
    uv[3] = '{8'h00, 8'hAB, 16'h0000};

    d_rst = 1'b1; d_in_valid = 1'b0; d_out_ready = 1'b0; d_a = '0; d_b = '0;
    u_rst = 1'b1; u_in_valid = 1'b0; u_out_ready = 1'b0; u_a = '0; u_b = '0;
    repeat (3) @(posedge clk);
    #1;
    d_rst = 1'b0; u_rst = 1'b0; g_rst = 1'b0;

    check("rst_in_ready",  64'(d_in_ready),  64'd1);
    check("rst_out_valid", 64'(d_out_valid), 64'd0);
    check("rst_product",   64'(d_prod),      64'd0);
    check("rst_u_product", 64'(u_prod),      64'd0);

    rnd_go = 1'b1;

    for (int i = 0; i < 10; i++) begin
      d_op(dv[i].a, dv[i].b, p, lat, busy_ok);
      $display("dflt vec %0d: a=%h b=%h product=%h latency=%0d", i, dv[i].a, dv[i].b, p, lat);
      check($sformatf("dflt_prod_%0d", i), 64'(p),       64'(dv[i].p));
      check($sformatf("dflt_lat_%0d", i),  64'(lat),     64'd6);
      check($sformatf("dflt_busy_%0d", i), 64'(busy_ok), 64'd1);
    end

    for (int i = 0; i < 4; i++) begin
      u_op(uv[i].a, uv[i].b, up, lat);
      $display("uns8 vec %0d: a=%h b=%h product=%h latency=%0d", i, uv[i].a, uv[i].b, up, lat);
      check($sformatf("uns_prod_%0d", i), 64'(up),  64'(uv[i].p));
      check($sformatf("uns_lat_%0d", i),  64'(lat), 64'd5);
    end

    // Back-pressure in DONE: 5 * -7 = -35
    d_a = 12'd5; d_b = 12'hFF9; d_in_valid = 1'b1; d_out_ready = 1'b0;
    @(posedge clk); #1;
    d_in_valid = 1'b0;
    t = 0;
    while (!d_out_valid && t < 50) begin @(posedge clk); #1; t++; end
    check("bp_prod", 64'(d_prod), 64'hFFFFDD);
    hold_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      d_in_valid = ~d_in_valid;
      d_a = 12'($urandom);
      d_b = 12'($urandom);
      @(posedge clk); #1;
      if (d_prod !== 24'hFFFFDD || d_in_ready !== 1'b0 || d_out_valid !== 1'b1) hold_ok = 1'b0;
    end
    check("bp_hold", 64'(hold_ok), 64'd1);
    d_in_valid = 1'b0; d_out_ready = 1'b1;
    @(posedge clk); #1;
    d_out_ready = 1'b0;
    $display("backpressure: product held, released after 10 cycles");
    check("bp_out_valid_drop", 64'(d_out_valid), 64'd0);
    check("bp_in_ready",       64'(d_in_ready),  64'd1);
    check("bp_prod_clear",     64'(d_prod),      64'd0);
    seen = 1'b0;
    repeat (8) begin @(posedge clk); #1; if (d_out_valid) seen = 1'b1; end
    check("bp_single_product", 64'(seen), 64'd0);

    // Reset during RUN step 3
    d_a = 12'd100; d_b = 12'd100; d_in_valid = 1'b1; d_out_ready = 1'b0;
    @(posedge clk); #1;
    d_in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    d_rst = 1'b1;
    @(posedge clk); #1;
    d_rst = 1'b0;
    check("midrst_in_ready",  64'(d_in_ready),  64'd1);
    check("midrst_out_valid", 64'(d_out_valid), 64'd0);
    check("midrst_product",   64'(d_prod),      64'd0);
    seen = 1'b0;
    repeat (10) begin @(posedge clk); #1; if (d_out_valid) seen = 1'b1; end
    check("midrst_no_pulse", 64'(seen), 64'd0);
    d_op(12'd7, 12'hFFD, p, lat, busy_ok);
    $display("after mid-run reset: a=7 b=-3 product=%h latency=%0d", p, lat);
    check("midrst_next_prod", 64'(p),   64'hFFFFEB);
    check("midrst_next_lat",  64'(lat), 64'd6);

    // Reset while a product is waiting in DONE
    d_a = 12'd3; d_b = 12'd5; d_in_valid = 1'b1; d_out_ready = 1'b0;
    @(posedge clk); #1;
    d_in_valid = 1'b0;
    t = 0;
    while (!d_out_valid && t < 50) begin @(posedge clk); #1; t++; end
    check("donerst_pre_valid", 64'(d_out_valid), 64'd1);
    d_rst = 1'b1;
    @(posedge clk); #1;
    d_rst = 1'b0;
    $display("reset in DONE applied");
    check("donerst_out_valid", 64'(d_out_valid), 64'd0);
    check("donerst_product",   64'(d_prod),      64'd0);
    check("donerst_in_ready",  64'(d_in_ready),  64'd1);

    t = 0;
    all_done = 1'b0;
    while (!all_done && t < 90000) begin
      all_done = 1'b1;
      for (int i = 0; i < 6; i++) if (!rnd_done[i]) all_done = 1'b0;
      if (!all_done) begin @(posedge clk); #1; t++; end
    end
    $display("random runs: %0d operands per configuration", RND_OPS);
    check("rnd_complete", 64'(all_done), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
